mips_mem_ctrl: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mem_array_sp.sv | 26 ++
 rtl/mips_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_mips_mem_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified memory controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int CNT_W         = 4;
  localparam int DEFAULT_DEPTH = 256;

endpackage

// File: rtl/mem_array_sp.sv
// Word-addressed single-port RAM with a registered read port and no content reset.
module mem_array_sp
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: dout reflects the contents prior to a same-cycle write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mips_mem_ctrl.sv
// Unified I/D memory with programmable wait states and a ready/err handshake.
// Optional MIPS_MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module mips_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int  DEPTH       = DEFAULT_DEPTH,
  parameter int  WAIT_CYCLES = 2,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
`ifdef MIPS_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  op_t              op_q;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q;

  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic [31:0]      ram_dout;
  logic             aligned;
  logic             accept;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^address[31:AW+2];
  assign aligned          = (addr_q[1:0] == 2'b00);
  assign accept           = (state == IDLE) && (mem_read ^ mem_write);

  // In IDLE the RAM looks at the live address so dout is already valid in ACCESS
  // even with zero wait states; afterwards it tracks the latched index.
  assign ram_addr = (state == IDLE) ? address[AW+1:2] : addr_q[AW+1:2];
  assign ram_we   = nrst && (state == ACCESS) && (op_q == OP_WR) && aligned;

  mem_array_sp #(
    .DEPTH (DEPTH),
    .DATA_W(32)
  ) u_array (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (wdata_q),
    .dout(ram_dout)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address[AW+1:0];
      wdata_q <= wdata;
      op_q    <= mem_write ? OP_WR : OP_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read && mem_write) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b1;
          end else if (accept) begin
            cnt   <= CNT_W'(WAIT_CYCLES);
            busy  <= 1'b1;
            state <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state <= RESP;
          ready <= 1'b1;
          err   <= !aligned;
          if (op_q == OP_RD && aligned) begin
            rdata <= ram_dout;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIPS_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == ACCESS && aligned) begin
      if (op_q == OP_RD && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (op_q == OP_WR && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Bench for mips_mem_ctrl: two instances (2 and 0 wait states) against an array model.
module tb_mips_mem_ctrl;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  always #5 clk = ~clk;

  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0, addr_b = '0, wd_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, busy_a, err_a, ready_b, busy_b, err_b;
`ifdef MIPS_MEM_STATS_EN
  logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  mips_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .nrst(nrst), .mem_read(rd_a), .mem_write(wr_a),
    .address(addr_a), .wdata(wd_a), .rdata(rdata_a),
    .ready(ready_a), .busy(busy_a), .err(err_a)
`ifdef MIPS_MEM_STATS_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );

  mips_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .nrst(nrst), .mem_read(rd_b), .mem_write(wr_b),
    .address(addr_b), .wdata(wd_b), .rdata(rdata_b),
    .ready(ready_b), .busy(busy_b), .err(err_b)
`ifdef MIPS_MEM_STATS_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2][DEPTH];
  logic [31:0] mrd [2];
  int          mrc [2];
  int          mwc [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 0) ? err_a : err_b;
  endfunction
  function automatic logic [31:0] get_rdata(input int s);
    return (s == 0) ? rdata_a : rdata_b;
  endfunction

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wd_a = d;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = a; wd_b = d;
    end
  endtask

  // One complete core transaction: request, wait for ready, release, then check.
  task automatic access(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    int   k;
    int   exp_lat;
    int   idx;
    logic conflict;
    logic mis;
    logic busy_ok;
    conflict = rd && wr;
    mis      = (a % 4) != 0;
    idx      = int'((a / 4) % DEPTH);
    exp_lat  = conflict ? 1 : ((s == 0) ? W + 2 : 2);
    @(negedge clk);
    drive(s, rd, wr, a, d);
    k       = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (!get_busy(s)) busy_ok = 1'b0;
    end while (!get_ready(s) && k < 20);
    drive(s, 1'b0, 1'b0, a, d);
    if (!conflict && !mis) begin
      if (wr) begin
        model[s][idx] = d;
        mwc[s]++;
      end else begin
        mrd[s] = model[s][idx];
        mrc[s]++;
      end
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("err", {31'd0, get_err(s)}, {31'd0, conflict || mis});
    check("rdata", get_rdata(s), mrd[s]);
    @(negedge clk);
    check("ready_pulse_width", {31'd0, get_ready(s)}, 32'd0);
    check("busy_release", {31'd0, get_busy(s)}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old20;
    logic [31:0] a;
    logic        seen;
    int          op;
    mrd[0] = '0; mrd[1] = '0;
    mrc[0] = 0;  mrc[1] = 0;
    mwc[0] = 0;  mwc[1] = 0;

    repeat (3) @(negedge clk);
    check("reset_rdata", rdata_a, 32'd0);
    check("reset_ready", {31'd0, ready_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_err", {31'd0, err_a}, 32'd0);
    check("reset_rdata0", rdata_b, 32'd0);
    check("reset_busy0", {31'd0, busy_b}, 32'd0);
    nrst = 1'b1;

    // Directed write/read-back first, then fill the rest of the array.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata_a, 32'hDEADBEEF);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 4) access(0, 1'b0, 1'b1, 32'(i * 4), $urandom);
    end

    access(0, 1'b0, 1'b1, 32'h13, 32'h1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("misaligned_no_write", rdata_a, 32'hDEADBEEF);

    access(0, 1'b1, 1'b1, 32'h10, 32'h55);
    access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("wrap_read", rdata_a, 32'hA5A5A5A5);

    // Reset while a write to 0x20 is still waiting.
    old20 = model[0][8];
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    mrd[0] = '0; mrd[1] = '0;
    mrc[0] = 0;  mrc[1] = 0;
    mwc[0] = 0;  mwc[1] = 0;
    check("midreset_busy", {31'd0, busy_a}, 32'd0);
    check("midreset_rdata", rdata_a, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (ready_a) seen = 1'b1;
      @(negedge clk);
    end
    check("midreset_no_ready", {31'd0, seen}, 32'd0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("midreset_old_data", rdata_a, old20);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      a  = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      if (op == 0)      access(0, 1'b1, 1'b1, a, $urandom);
      else if (op < 5)  access(0, 1'b1, 1'b0, a, 32'h0);
      else              access(0, 1'b0, 1'b1, a, $urandom);
    end

    // Zero-wait-state instance.
    access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    access(1, 1'b0, 1'b1, 32'h44, $urandom);
    access(1, 1'b1, 1'b0, 32'h40, 32'h0);
    check("nowait_read", rdata_b, 32'hCAFEF00D);
    access(1, 1'b1, 1'b1, 32'h40, 32'h0);
    access(1, 1'b1, 1'b0, 32'h46, 32'h0);
    access(1, 1'b1, 1'b0, 32'h44, 32'h0);

`ifdef MIPS_MEM_STATS_EN
    check("rd_count", {16'd0, rdc_a}, 32'(mrc[0] > 65535 ? 65535 : mrc[0]));
    check("wr_count", {16'd0, wrc_a}, 32'(mwc[0] > 65535 ? 65535 : mwc[0]));
    check("rd_count0", {16'd0, rdc_b}, 32'(mrc[1]));
    check("wr_count0", {16'd0, wrc_b}, 32'(mwc[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
